// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with credit-based request issue,
// in-order response buffering and redirect/flush handling.
//
// Ports:
//   clk, rst_n       - clock; synchronous active-low reset
//   imem_req_*       - fetch request channel (valid/ready, word address)
//   imem_rsp_*       - in-order instruction return (valid, data)
//   redirect_*       - taken branch/jump: restart fetch at redirect_pc
//   if_valid/if_ready- instruction handoff to decode
//   if_instr/if_pc   - head instruction word and its address
//   if_opcode        - if_instr[6:0]
//   fetch_fault      - misaligned redirect target; fetch halted
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [6:0]  if_opcode,
    output logic [31:0] if_pc,
    output logic        fetch_fault
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam int unsigned SW = CW + 1;
    localparam int unsigned PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } entry_t;

    state_t          state;
    logic [31:0]     pc;
    logic [CW-1:0]   outstanding;   // all in-flight requests, including ones to be dropped
    logic [CW-1:0]   drop_count;    // oldest in-flight responses to discard
    logic [CW-1:0]   buf_count;

    // Address queue holds pcs of live (non-dropped) requests only.
    logic [31:0]     aq_mem [MAX_OUT];
    logic [PW-1:0]   aq_rd;
    logic [PW-1:0]   aq_wr;

    entry_t          fifo_mem [MAX_OUT];
    logic [PW-1:0]   fifo_rd;
    logic [PW-1:0]   fifo_wr;

    logic            req_fire;
    logic            rsp_take;
    logic            rsp_drop;
    logic            rsp_push;
    logic            pop;
    logic            credit_ok;
    logic [CW-1:0]   inflight_next;
    entry_t          head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + PW'(1);
    endfunction

    // Request issue: credit covers in-flight plus buffered entries.
    assign credit_ok      = (SW'(outstanding) + SW'(buf_count)) < SW'(MAX_OUT);
    assign imem_req_valid = rst_n && (state == RUN) && !redirect_valid && credit_ok;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Response classification; a response with nothing in flight is ignored.
    assign rsp_take      = imem_rsp_valid && (outstanding != '0);
    assign rsp_drop      = rsp_take && (drop_count != '0);
    assign rsp_push      = rsp_take && (drop_count == '0) && !redirect_valid;
    assign inflight_next = outstanding - CW'(rsp_take);

    // Decode handoff from the FIFO head; redirect wins over a pop.
    assign head      = fifo_mem[fifo_rd];
    assign if_valid  = (buf_count != '0);
    assign if_instr  = if_valid ? head.data : '0;
    assign if_pc     = if_valid ? head.pc : '0;
    assign if_opcode = if_instr[6:0];
    assign pop       = if_valid && if_ready && !redirect_valid;

    // State, pc, counters and queues.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            // Requests abandoned by reset still return; drop them as they arrive.
            outstanding <= inflight_next;
            drop_count  <= inflight_next;
            buf_count   <= '0;
            aq_rd       <= '0;
            aq_wr       <= '0;
            fifo_rd     <= '0;
            fifo_wr     <= '0;
            fetch_fault <= 1'b0;
        end else begin
            if (state == IDLE) begin
                state <= RUN;
            end
            if (redirect_valid) begin
                pc          <= redirect_pc;
                outstanding <= inflight_next;
                drop_count  <= inflight_next;
                buf_count   <= '0;
                aq_rd       <= aq_wr;
                fifo_rd     <= fifo_wr;
                if (redirect_pc[1:0] == 2'b00) begin
                    state       <= RUN;
                    fetch_fault <= 1'b0;
                end else begin
                    state       <= FAULT;
                    fetch_fault <= 1'b1;
                end
            end else begin
                if (req_fire) begin
                    aq_mem[aq_wr] <= pc;
                    aq_wr         <= ptr_inc(aq_wr);
                    pc            <= pc + 32'd4;
                end
                if (rsp_drop) begin
                    drop_count <= drop_count - CW'(1);
                end
                if (rsp_push) begin
                    fifo_mem[fifo_wr] <= '{pc: aq_mem[aq_rd], data: imem_rsp_data};
                    fifo_wr           <= ptr_inc(fifo_wr);
                    aq_rd             <= ptr_inc(aq_rd);
                end
                if (pop) begin
                    fifo_rd <= ptr_inc(fifo_rd);
                end
                outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
                buf_count   <= buf_count + CW'(rsp_push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit. The reference
// model is the architectural fetch stream: after reset or a redirect, decode
// must see pc, pc+4, ... with each word equal to memory contents at that pc.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int          MAX_OUT    = 2;
    localparam int          NUM_CYCLES = 3000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;
    logic [31:0] if_pc;
    logic        fetch_fault;

    fetch_unit #(.RESET_PC(RESET_PC), .MAX_OUT(MAX_OUT)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode),
        .if_pc          (if_pc),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t mem_q[$];

    int checks   = 0;
    int errors   = 0;
    int consumed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every decode handshake must match the next expected fetch.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && if_valid && if_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc 0x%08h, expected no instruction", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("if_pc", if_pc, e.pc);
                    check("if_instr", if_instr, e.instr);
                    check("if_opcode", 32'(if_opcode), 32'(e.instr[6:0]));
                    consumed++;
                end
            end
        end
    end

    // Stimulus, memory model and architectural model.
    initial begin
        logic [31:0] model_req_pc;
        logic        model_fault;
        logic        model_idle;
        logic        prev_reset;
        logic        prev_redirect;
        logic        prev_hold_if;
        logic        prev_hold_req;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        logic [31:0] prev_addr;
        logic [31:0] tgt;
        int          lat;

        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        if_ready       = 1'b0;
        model_req_pc   = RESET_PC;
        model_fault    = 1'b0;
        model_idle     = 1'b1;
        prev_reset     = 1'b0;
        prev_redirect  = 1'b0;
        prev_hold_if   = 1'b0;
        prev_hold_req  = 1'b0;
        prev_pc        = '0;
        prev_instr     = '0;
        prev_addr      = '0;
        lat            = 1;

        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(negedge clk);

            // Registered state left by the previous edge.
            if (prev_reset) begin
                check("rst_req_valid", 32'(imem_req_valid), 32'd0);
                check("rst_if_valid", 32'(if_valid), 32'd0);
                check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
                check("rst_if_instr", if_instr, 32'd0);
                check("rst_if_pc", if_pc, 32'd0);
            end else if (cyc > 0) begin
                check("fetch_fault", 32'(fetch_fault), 32'(model_fault));
                if (prev_redirect) begin
                    check("flush_if_valid", 32'(if_valid), 32'd0);
                end
                if (prev_hold_if) begin
                    check("hold_if_valid", 32'(if_valid), 32'd1);
                    check("hold_if_pc", if_pc, prev_pc);
                    check("hold_if_instr", if_instr, prev_instr);
                end
                if (prev_hold_req) begin
                    check("hold_req_valid", 32'(imem_req_valid), 32'd1);
                    check("hold_req_addr", imem_req_addr, prev_addr);
                end
            end

            // Drive this cycle's inputs.
            rst_n = !(cyc < 4 || cyc == 1500 || cyc == 1501 || cyc == 2500);
            redirect_valid = 1'b0;
            redirect_pc    = 32'($urandom);
            if (cyc < 40) begin
                imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1;
            end else if (cyc < 50) begin
                imem_req_ready = 1'b1; if_ready = 1'b0; lat = 1;
            end else if (cyc < 100) begin
                imem_req_ready = 1'b1; if_ready = 1'b1; lat = 2;
            end else if (cyc < 105) begin
                imem_req_ready = 1'b0; if_ready = 1'b1; lat = 1;
            end else if (cyc < 110) begin
                imem_req_ready = 1'b1; if_ready = 1'b1; lat = 1;
            end else begin
                imem_req_ready = ($urandom_range(0, 99) < 75);
                if_ready       = ($urandom_range(0, 99) < 70);
                lat            = $urandom_range(1, 4);
            end

            if (cyc == 60) begin
                redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
            end else if (cyc == 80) begin
                redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
            end else if (cyc == 90) begin
                redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
            end else if (cyc >= 110 && rst_n &&
                         $urandom_range(0, 99) < (model_fault ? 25 : 3)) begin
                tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0
                                                  : 32'($urandom_range(0, 32'h3FFF)) << 2;
                if ($urandom_range(0, 4) == 0) begin
                    tgt = tgt | 32'($urandom_range(1, 3));
                end
                redirect_valid = 1'b1;
                redirect_pc    = tgt;
            end

            // Memory returns words in order, each no earlier than its due cycle.
            if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_q[0].data;
                void'(mem_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = 32'($urandom);
            end

            #1;

            // Request side, with inputs settled for the coming edge.
            if (!rst_n || redirect_valid || model_fault || model_idle) begin
                check("req_valid_blocked", 32'(imem_req_valid), 32'd0);
            end else if (imem_req_valid) begin
                check("req_credit", 32'(exp_q.size() < MAX_OUT), 32'd1);
            end
            if (rst_n && imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, model_req_pc);
                exp_q.push_back('{pc: model_req_pc, instr: mem_word(model_req_pc)});
                mem_q.push_back('{data: mem_word(imem_req_addr), due: cyc + lat});
                model_req_pc = model_req_pc + 32'd4;
            end

            prev_hold_if  = rst_n && if_valid && !if_ready && !redirect_valid;
            prev_pc       = if_pc;
            prev_instr    = if_instr;
            prev_hold_req = rst_n && imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr     = imem_req_addr;
            prev_redirect = rst_n && redirect_valid;
            prev_reset    = !rst_n;

            if (!rst_n) begin
                exp_q.delete();
                model_req_pc = RESET_PC;
                model_fault  = 1'b0;
                model_idle   = 1'b1;
            end else begin
                model_idle = 1'b0;
                if (redirect_valid) begin
                    exp_q.delete();
                    model_req_pc = redirect_pc;
                    model_fault  = (redirect_pc[1:0] != 2'b00);
                end
            end
        end

        check("progress", 32'(consumed > 200), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
